dcache_mem_ctrl: RTL and testbench

Memory-side responder for the data cache's line-miss interface. It accepts a line fill or dirty-line writeback request from the data cache and turns it into byte-serial RAM accesses. It returns either a filled line (`memDataValid`) or a writeback acknowledge (`acceptWrite`). It sits between the data cache and the 8-bit single-port RAM bus.

---
 rtl/dcache_mem_ctrl_if.sv | 33 +++
 rtl/dcache_mem_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dcache_mem_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_mem_ctrl_if.sv
// Line-miss bus between the data cache and its memory controller, plus the
// byte-wide single-port RAM bus the controller drives.
interface dcache_mem_ctrl_if #(
    parameter int BLOCK_WIDTH = 4
);
    localparam int BLOCK_SIZE = 2**BLOCK_WIDTH;

    logic                      readyIn;
    logic                      miss;
    logic [31:BLOCK_WIDTH]     missAddr;
    logic                      readWriteIn;
    logic [BLOCK_SIZE*8-1:0]   writeBackIn;
    logic                      memDataValid;
    logic [31:BLOCK_WIDTH]     memAddr;
    logic [BLOCK_SIZE*8-1:0]   memDataOut;
    logic                      acceptWrite;
    logic [7:0]                ramDataIn;
    logic [7:0]                ramDataOut;
    logic [31:0]               ramAddr;
    logic                      ramWrite;

    modport master (
        output readyIn, miss, missAddr, readWriteIn, writeBackIn, ramDataIn,
        input  memDataValid, memAddr, memDataOut, acceptWrite,
        input  ramDataOut, ramAddr, ramWrite
    );

    modport slave (
        input  readyIn, miss, missAddr, readWriteIn, writeBackIn, ramDataIn,
        output memDataValid, memAddr, memDataOut, acceptWrite,
        output ramDataOut, ramAddr, ramWrite
    );
endinterface

// File: rtl/dcache_mem_ctrl.sv
// Serves data-cache line fills and writebacks as byte-serial RAM accesses.
// Optional request statistics counters are enabled with DCACHE_MEM_STATS_EN.
module dcache_mem_ctrl #(
    parameter int BLOCK_WIDTH = 4
) (
    input  logic        clkIn,
    input  logic        resetIn,
`ifdef DCACHE_MEM_STATS_EN
    output logic [31:0] fillCount,
    output logic [31:0] writeBackCount,
`endif
    dcache_mem_ctrl_if.slave bus
);
    localparam int BLOCK_SIZE = 2**BLOCK_WIDTH;
    localparam int LINE_BITS  = BLOCK_SIZE * 8;
    localparam int LINE_AW    = 32 - BLOCK_WIDTH;
    localparam logic [BLOCK_WIDTH:0] CNT_FULL = (BLOCK_WIDTH+1)'(BLOCK_SIZE);
    localparam logic [BLOCK_WIDTH:0] CNT_LAST = (BLOCK_WIDTH+1)'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [BLOCK_WIDTH:0]   cnt_q, cnt_d;
    logic [LINE_AW-1:0]     line_addr_q, line_addr_d;
    logic                   rd_q, rd_d;
    logic [LINE_BITS-1:0]   line_buf_q, line_buf_d;
    logic                   mem_data_valid_q, mem_data_valid_d;
    logic                   accept_write_q, accept_write_d;
    logic [LINE_AW-1:0]     mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0]   mem_data_out_q, mem_data_out_d;
    logic [7:0]             ram_data_out_q, ram_data_out_d;
    logic [31:0]            ram_addr_q, ram_addr_d;
    logic                   ram_write_q, ram_write_d;

    logic [BLOCK_WIDTH-1:0] cnt_lo, next_lo, cap_idx;
    logic [7:0]             line_byte [BLOCK_SIZE];

    generate
        for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_byte
            assign line_byte[gi] = line_buf_q[gi*8 +: 8];
        end
    endgenerate

    assign cnt_lo  = cnt_q[BLOCK_WIDTH-1:0];
    assign next_lo = cnt_lo + 1'b1;
    // At cnt == BLOCK_SIZE the low bits are zero, so this wraps to the last byte.
    assign cap_idx = cnt_lo - 1'b1;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        line_addr_d      = line_addr_q;
        rd_d             = rd_q;
        line_buf_d       = line_buf_q;
        mem_data_valid_d = 1'b0;
        accept_write_d   = 1'b0;
        mem_addr_d       = mem_addr_q;
        mem_data_out_d   = mem_data_out_q;
        ram_data_out_d   = ram_data_out_q;
        ram_addr_d       = ram_addr_q;
        ram_write_d      = ram_write_q;

        case (state_q)
            IDLE: begin
                ram_write_d = 1'b0;
                ram_addr_d  = '0;
                if (bus.miss) begin
                    line_addr_d = bus.missAddr;
                    rd_d        = bus.readWriteIn;
                    line_buf_d  = bus.writeBackIn;
                    cnt_d       = '0;
                    ram_addr_d  = {bus.missAddr, {BLOCK_WIDTH{1'b0}}};
                    if (bus.readWriteIn) begin
                        state_d = READ;
                    end else begin
                        state_d        = WRITE;
                        ram_write_d    = 1'b1;
                        ram_data_out_d = bus.writeBackIn[7:0];
                    end
                end
            end
            READ: begin
                cnt_d = cnt_q + 1'b1;
                // RAM read data lags the address by one cycle.
                if (cnt_q != '0) begin
                    line_buf_d[{cap_idx, 3'b000} +: 8] = bus.ramDataIn;
                end
                if (cnt_q == CNT_FULL) begin
                    state_d          = DONE;
                    cnt_d            = cnt_q;
                    mem_data_valid_d = 1'b1;
                    mem_addr_d       = line_addr_q;
                    mem_data_out_d   = line_buf_d;
                    ram_addr_d       = '0;
                end else if (cnt_q < CNT_LAST) begin
                    ram_addr_d = {line_addr_q, next_lo};
                end
            end
            WRITE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d        = DONE;
                    accept_write_d = 1'b1;
                    mem_addr_d     = line_addr_q;
                    ram_write_d    = 1'b0;
                    ram_addr_d     = '0;
                    ram_data_out_d = '0;
                end else begin
                    cnt_d          = cnt_q + 1'b1;
                    ram_addr_d     = {line_addr_q, next_lo};
                    ram_data_out_d = line_byte[next_lo];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            line_addr_q      <= '0;
            rd_q             <= 1'b0;
            line_buf_q       <= '0;
            mem_data_valid_q <= 1'b0;
            accept_write_q   <= 1'b0;
            mem_addr_q       <= '0;
            mem_data_out_q   <= '0;
            ram_data_out_q   <= '0;
            ram_addr_q       <= '0;
            ram_write_q      <= 1'b0;
        end else if (bus.readyIn) begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            line_addr_q      <= line_addr_d;
            rd_q             <= rd_d;
            line_buf_q       <= line_buf_d;
            mem_data_valid_q <= mem_data_valid_d;
            accept_write_q   <= accept_write_d;
            mem_addr_q       <= mem_addr_d;
            mem_data_out_q   <= mem_data_out_d;
            ram_data_out_q   <= ram_data_out_d;
            ram_addr_q       <= ram_addr_d;
            ram_write_q      <= ram_write_d;
        end
    end

    assign bus.memDataValid = mem_data_valid_q;
    assign bus.acceptWrite  = accept_write_q;
    assign bus.memAddr      = mem_addr_q;
    assign bus.memDataOut   = mem_data_out_q;
    assign bus.ramDataOut   = ram_data_out_q;
    assign bus.ramAddr      = ram_addr_q;
    // A stalled write must not be repeated by the RAM.
    assign bus.ramWrite     = ram_write_q & bus.readyIn;

`ifdef DCACHE_MEM_STATS_EN
    logic [31:0] fill_count_q, fill_count_d;
    logic [31:0] wb_count_q, wb_count_d;

    always_comb begin
        fill_count_d = fill_count_q + {31'd0, mem_data_valid_d};
        wb_count_d   = wb_count_q + {31'd0, accept_write_d};
    end

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            fill_count_q <= '0;
            wb_count_q   <= '0;
        end else if (bus.readyIn) begin
            fill_count_q <= fill_count_d;
            wb_count_q   <= wb_count_d;
        end
    end

    assign fillCount      = fill_count_q;
    assign writeBackCount = wb_count_q;
`endif
endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Randomized bench for dcache_mem_ctrl against a RAM model and request-level
// timing/data expectations.
module tb_dcache_mem_ctrl;
    localparam int BW = 4;
    localparam int BS = 16;

    logic clkIn = 1'b0;
    logic resetIn;
    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;
    int exp_fills = 0;
    int exp_wbs = 0;
    int req_no = 0;
    logic [27:0] model_mem_addr = '0;
    logic [7:0]  mem [65536];

    dcache_mem_ctrl_if #(.BLOCK_WIDTH(BW)) bus ();

`ifdef DCACHE_MEM_STATS_EN
    logic [31:0] fill_count;
    logic [31:0] wb_count;
`endif

    dcache_mem_ctrl #(.BLOCK_WIDTH(BW)) dut (
        .clkIn          (clkIn),
        .resetIn        (resetIn),
`ifdef DCACHE_MEM_STATS_EN
        .fillCount      (fill_count),
        .writeBackCount (wb_count),
`endif
        .bus            (bus)
    );

    always #5 clkIn = ~clkIn;
    always @(posedge clkIn) cyc <= cyc + 1;

    // Byte-wide RAM with registered read; readyIn gates it like the rest of the system.
    initial begin
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] a;
            a = 16'(i);
            mem[i] <= a[7:0] ^ {4'(a[11:8] - 4'd1), a[15:12]};
        end
        bus.ramDataIn <= 8'h00;
        forever begin
            @(posedge clkIn);
            if (bus.readyIn === 1'b1) begin
                if (bus.ramWrite === 1'b1) mem[bus.ramAddr[15:0]] <= bus.ramDataOut;
                bus.ramDataIn <= mem[bus.ramAddr[15:0]];
            end
        end
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Call right after a falling edge; that cycle becomes T, the cycle miss is sampled.
    task automatic run_req(input bit rw, input logic [27:0] line, input logic [127:0] wb,
                           input int stall_at, input int stall_len, input bit hold_after);
        int unsigned t0;
        int a;
        int stalled;
        int lat;
        bit done;
        bit prev_ready;
        logic [127:0] exp_fill;
        logic [127:0] got_mem;
        logic [31:0] base;
        base = {line, 4'h0};
        for (int k = 0; k < BS; k++) exp_fill[k*8 +: 8] = mem[base[15:0] + 16'(k)];
        lat = rw ? BS + 2 : BS + 1;
        bus.miss        = 1'b1;
        bus.missAddr    = line;
        bus.readWriteIn = rw;
        bus.writeBackIn = wb;
        bus.readyIn     = 1'b1;
        t0 = cyc;
        a = 0;
        stalled = 0;
        done = 1'b0;
        #1;
        check_val("idle_addr", bus.ramAddr, 0);
        check_val("idle_wr", bus.ramWrite, 0);
        for (int n = 0; n < 64 && !done; n++) begin
            prev_ready = bus.readyIn;
            @(negedge clkIn);
            if (prev_ready) a++;
            bus.readyIn = 1'b1;
            if (stall_len > 0 && a == stall_at && stalled < stall_len) begin
                bus.readyIn = 1'b0;
                stalled++;
            end
            bus.writeBackIn = {$urandom(), $urandom(), $urandom(), $urandom()};
            #1;
            if (!bus.readyIn) begin
                check_val("stall_wr", bus.ramWrite, 0);
            end else if (a >= 1 && a <= BS) begin
                check_val("ram_addr", bus.ramAddr, base + 32'(a - 1));
                check_val("ram_wr", bus.ramWrite, !rw);
                if (!rw) check_val("ram_wdata", bus.ramDataOut, wb[(a-1)*8 +: 8]);
            end
            if (bus.memDataValid || bus.acceptWrite) begin
                done = 1'b1;
                check_val("pulse_cyc", cyc - t0, lat + stall_len);
                check_val("pulse_kind", {bus.memDataValid, bus.acceptWrite}, rw ? 2'b10 : 2'b01);
                check_val("mem_addr", bus.memAddr, line);
                model_mem_addr = line;
                if (rw) begin
                    check_val("fill_data", bus.memDataOut, exp_fill);
                    exp_fills++;
                end else begin
                    exp_wbs++;
                end
                if (!hold_after) bus.miss = 1'b0;
            end else begin
                check_val("mem_addr_hold", bus.memAddr, model_mem_addr);
            end
        end
        check_val("no_timeout", done, 1);
        if (!rw) begin
            for (int k = 0; k < BS; k++) got_mem[k*8 +: 8] = mem[base[15:0] + 16'(k)];
            check_val("wb_mem", got_mem, wb);
        end
        $display("req %0d %s line=%07h stall=%0d@%0d cycles=%0d", req_no, rw ? "fill" : "wb  ",
                 line, stall_len, stall_at, cyc - t0);
        req_no++;
    endtask

    initial begin
        logic [127:0] fill_10;
        logic [127:0] wb_a;
        logic [127:0] wb_b;
        bit prev_hold;
        bit rw;
        int st_at;
        int st_len;
        fill_10 = 128'h0f0e0d0c0b0a09080706050403020100;
        wb_a    = 128'h5a5b5c5d5e5f60616263646566676869;
        wb_b    = 128'hc3c2c1c0bfbebdbcbbbab9b8b7b6b5b4;

        resetIn         = 1'b0;
        bus.readyIn     = 1'b1;
        bus.miss        = 1'b1;
        bus.missAddr    = 28'h10;
        bus.readWriteIn = 1'b1;
        bus.writeBackIn = '0;
        repeat (3) @(negedge clkIn);
        #1;
        check_val("rst_valid", bus.memDataValid, 0);
        check_val("rst_accept", bus.acceptWrite, 0);
        check_val("rst_memaddr", bus.memAddr, 0);
        check_val("rst_memdata", bus.memDataOut, 0);
        check_val("rst_ramdout", bus.ramDataOut, 0);
        check_val("rst_ramaddr", bus.ramAddr, 0);
        check_val("rst_ramwr", bus.ramWrite, 0);
        bus.miss = 1'b0;
        @(negedge clkIn);
        resetIn = 1'b1;

        @(negedge clkIn);
        run_req(1'b1, 28'h10, '0, 0, 0, 1'b0);
        check_val("tp_fill_const", bus.memDataOut, fill_10);

        @(negedge clkIn);
        run_req(1'b0, 28'h20, 128'hffeeddccbbaa99887766554433221100, 0, 0, 1'b1);
        @(negedge clkIn);
        run_req(1'b1, 28'h30, '0, 0, 0, 1'b0);

        @(negedge clkIn);
        run_req(1'b1, 28'h10, '0, 6, 3, 1'b0);
        check_val("stall_fill_const", bus.memDataOut, fill_10);

        @(negedge clkIn);
        bus.miss        = 1'b1;
        bus.missAddr    = 28'h20;
        bus.readWriteIn = 1'b0;
        bus.writeBackIn = wb_a;
        bus.readyIn     = 1'b1;
        repeat (9) @(negedge clkIn);
        resetIn = 1'b0;
        exp_fills = 0;
        exp_wbs = 0;
        model_mem_addr = '0;
        #1;
        check_val("mid_rst_ramwr", bus.ramWrite, 0);
        check_val("mid_rst_ramaddr", bus.ramAddr, 0);
        check_val("mid_rst_ramdout", bus.ramDataOut, 0);
        check_val("mid_rst_accept", bus.acceptWrite, 0);
        check_val("mid_rst_valid", bus.memDataValid, 0);
        check_val("mid_rst_memaddr", bus.memAddr, 0);
        check_val("mid_rst_memdata", bus.memDataOut, 0);
        check_val("mid_rst_byte7", mem[16'h0207], wb_a[63:56]);
        check_val("mid_rst_byte8", mem[16'h0208], 8'h88);
        @(negedge clkIn);
        #1;
        check_val("mid_rst_accept2", bus.acceptWrite, 0);
        @(negedge clkIn);
        resetIn = 1'b1;
        run_req(1'b0, 28'h20, wb_b, 0, 0, 1'b0);

        prev_hold = 1'b0;
        for (int r = 0; r < 40; r++) begin
            @(negedge clkIn);
            if (!prev_hold) repeat ($urandom_range(0, 2)) @(negedge clkIn);
            rw = 1'($urandom_range(0, 1));
            st_at = 0;
            st_len = 0;
            if ($urandom_range(0, 2) == 0) begin
                st_at  = $urandom_range(1, 15);
                st_len = $urandom_range(1, 3);
            end
            prev_hold = 1'($urandom_range(0, 1));
            run_req(rw, 28'($urandom_range(0, 4095)),
                    {$urandom(), $urandom(), $urandom(), $urandom()}, st_at, st_len, prev_hold);
        end
        bus.miss = 1'b0;

`ifdef DCACHE_MEM_STATS_EN
        @(negedge clkIn);
        #1;
        check_val("fill_count", fill_count, exp_fills);
        check_val("wb_count", wb_count, exp_wbs);
`endif

        @(negedge clkIn);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
